// File: rtl/prewish_button_poller.sv
// prewish_button_poller: periodically requests a status byte from a button
// source over a strobe handshake, detects button edges and presents them to
// the caller as a pending event with sticky timeout/overflow flags.
// Optional build macro: PREWISH_POLL_RELEASE_EVT_EN (report release edges too).
module prewish_button_poller #(
    parameter int POLL_PERIOD = 100000,
    parameter int POLL_BITS   = 17,
    parameter int TIMEOUT     = 15
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       EN_I,
    output logic       POLL_STB_O,
    input  logic       POLL_STB_I,
    input  logic [7:0] POLL_DAT_I,
    output logic       STB_O,
    output logic [7:0] EVT_O,
    output logic [7:0] DAT_O,
    input  logic       ACK_I,
    input  logic       CLR_I,
    output logic       ERR_O,
    output logic       OVF_O
);

    localparam int TMO_BITS = $clog2(TIMEOUT);
    localparam logic [POLL_BITS-1:0] PERIOD_RLD = POLL_BITS'(POLL_PERIOD - 1);
    localparam logic [TMO_BITS-1:0]  TMO_RLD    = TMO_BITS'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, CMP} state_t;

    state_t               state, nxt;
    logic [POLL_BITS-1:0] cnt;
    logic [TMO_BITS-1:0]  tmo;
    logic [7:0]           cur, prev, evt;
    logic                 poll_fire, wait_hit, wait_tmo, in_cmp;
    logic                 evt_any, ovf_set;

    // State register.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state and per-state decode.
    always_comb begin
        nxt       = state;
        poll_fire = 1'b0;
        wait_hit  = 1'b0;
        wait_tmo  = 1'b0;
        in_cmp    = 1'b0;
        case (state)
            IDLE: begin
                if (EN_I && cnt == '0) begin
                    poll_fire = 1'b1;
                    nxt       = REQ;
                end
            end
            REQ:  nxt = WAIT;
            WAIT: begin
                // A reply on the last allowed cycle still wins over the timeout.
                if (POLL_STB_I) begin
                    wait_hit = 1'b1;
                    nxt      = CMP;
                end else if (tmo == '0) begin
                    wait_tmo = 1'b1;
                    nxt      = IDLE;
                end
            end
            CMP: begin
                in_cmp = 1'b1;
                nxt    = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Request strobe is a pure decode of the one-cycle REQ state.
    assign POLL_STB_O = (state == REQ);

`ifdef PREWISH_POLL_RELEASE_EVT_EN
    assign evt = cur ^ prev;
`else
    assign evt = cur & ~prev;
`endif

    assign evt_any = (evt != 8'h00);
    // Merge into an event the caller has neither taken nor is taking now.
    assign ovf_set = in_cmp && evt_any && STB_O && !ACK_I;

    // Poll period counter: runs only in IDLE while enabled, parked otherwise.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            cnt <= PERIOD_RLD;
        end else if (state == IDLE) begin
            if (!EN_I || poll_fire) cnt <= PERIOD_RLD;
            else                    cnt <= cnt - 1'b1;
        end
    end

    // Reply timeout counter: loaded in REQ, counts down through WAIT.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I)                           tmo <= '0;
        else if (state == REQ)                tmo <= TMO_RLD;
        else if (state == WAIT && tmo != '0)  tmo <= tmo - 1'b1;
    end

    // Status capture and history; a timed-out poll leaves both untouched.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            cur   <= 8'h00;
            prev  <= 8'h00;
            DAT_O <= 8'h00;
        end else begin
            if (wait_hit) cur <= POLL_DAT_I;
            if (in_cmp) begin
                prev  <= cur;
                DAT_O <= cur;
            end
        end
    end

    // Pending event: new, merged, replaced on ack, or retired on ack.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            STB_O <= 1'b0;
            EVT_O <= 8'h00;
        end else if (in_cmp && evt_any) begin
            STB_O <= 1'b1;
            if (STB_O && !ACK_I) EVT_O <= EVT_O | evt;
            else                 EVT_O <= evt;
        end else if (STB_O && ACK_I) begin
            STB_O <= 1'b0;
            EVT_O <= 8'h00;
        end
    end

    // Sticky flags: a set in the same cycle beats the clear.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            ERR_O <= 1'b0;
            OVF_O <= 1'b0;
        end else begin
            if (wait_tmo)   ERR_O <= 1'b1;
            else if (CLR_I) ERR_O <= 1'b0;
            if (ovf_set)    OVF_O <= 1'b1;
            else if (CLR_I) OVF_O <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prewish_button_poller.sv
// Directed bench for prewish_button_poller (POLL_PERIOD=8, TIMEOUT=4) with a
// status source that answers two cycles after each request.
module tb_prewish_button_poller;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic       EN_I  = 1'b0;
    logic       POLL_STB_O;
    logic       POLL_STB_I;
    logic [7:0] POLL_DAT_I;
    logic       STB_O;
    logic [7:0] EVT_O;
    logic [7:0] DAT_O;
    logic       ACK_I = 1'b0;
    logic       CLR_I = 1'b0;
    logic       ERR_O;
    logic       OVF_O;

    logic [7:0] src_byte = 8'h00;
    logic       silent   = 1'b0;
    logic       d1 = 1'b0, d2 = 1'b0;
    int         total = 0;
    int         bad   = 0;
    int         n;

    prewish_button_poller #(.POLL_PERIOD(8), .POLL_BITS(3), .TIMEOUT(4)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .EN_I(EN_I),
        .POLL_STB_O(POLL_STB_O), .POLL_STB_I(POLL_STB_I), .POLL_DAT_I(POLL_DAT_I),
        .STB_O(STB_O), .EVT_O(EVT_O), .DAT_O(DAT_O), .ACK_I(ACK_I),
        .CLR_I(CLR_I), .ERR_O(ERR_O), .OVF_O(OVF_O)
    );

    always #5 CLK_I = ~CLK_I;

    // Status source: sees the request on the next edge, answers one edge later.
    always @(posedge CLK_I) begin
        d1 <= POLL_STB_O;
        d2 <= d1;
    end
    assign POLL_STB_I = d2 & ~silent;
    assign POLL_DAT_I = src_byte;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge CLK_I);
    endtask

    // Step negedges until the request strobe is seen (bounded).
    task automatic wait_req(output int cnt);
        cnt = 0;
        do begin
            tick(1);
            cnt++;
        end while (!POLL_STB_O && cnt < 40);
    endtask

    task automatic ack_pulse;
        ACK_I = 1'b1;
        tick(1);
        ACK_I = 1'b0;
    endtask

    task automatic clr_pulse;
        CLR_I = 1'b1;
        tick(1);
        CLR_I = 1'b0;
    endtask

    initial begin
        // Reset state
        #2 RST_I = 1'b0;
        tick(3);
        chk("rst_pstb", POLL_STB_O, 0);
        chk("rst_stb",  STB_O, 0);
        chk("rst_evt",  EVT_O, 0);
        chk("rst_dat",  DAT_O, 0);
        chk("rst_err",  ERR_O, 0);
        chk("rst_ovf",  OVF_O, 0);
        RST_I = 1'b1;

        // Disabled: no requests at all
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (POLL_STB_O) n++;
        end
        chk("dis_noreq", n, 0);

        // First poll lands 8 cycles after enable; strobe is one cycle wide
        src_byte = 8'h00;
        EN_I = 1'b1;
        wait_req(n);
        chk("first_req_dly", n, 8);
        tick(1);
        chk("req_one_cyc", POLL_STB_O, 0);
        tick(3);
        chk("p0_stb", STB_O, 0);
        chk("p0_dat", DAT_O, 8'h00);

        // Press 00->01; STB_O rises 4 cycles after the request cycle
        src_byte = 8'h01;
        wait_req(n);
        chk("p1_req", POLL_STB_O, 1);
        tick(3);
        chk("p1_lat_pre", STB_O, 0);
        tick(1);
        chk("p1_stb", STB_O, 1);
        chk("p1_evt", EVT_O, 8'h01);
        chk("p1_dat", DAT_O, 8'h01);
        ack_pulse();
        chk("p1_ack_stb", STB_O, 0);
        chk("p1_ack_evt", EVT_O, 8'h00);

        // Release 01->00
        src_byte = 8'h00;
        wait_req(n);
        tick(4);
        chk("rel_dat", DAT_O, 8'h00);
`ifdef PREWISH_POLL_RELEASE_EVT_EN
        chk("rel_stb", STB_O, 1);
        chk("rel_evt", EVT_O, 8'h01);
`else
        chk("rel_stb", STB_O, 0);
`endif
        // Ack retires the release event, or does nothing if none is pending
        ack_pulse();
        chk("ack_idle_stb", STB_O, 0);
        chk("ack_idle_evt", EVT_O, 8'h00);

        // 00->01 then 01->03 without ack: merge and overflow
        src_byte = 8'h01;
        wait_req(n);
        tick(4);
        chk("m1_evt", EVT_O, 8'h01);
        chk("m1_ovf", OVF_O, 0);
        src_byte = 8'h03;
        wait_req(n);
        tick(4);
        chk("m2_evt", EVT_O, 8'h03);
        chk("m2_stb", STB_O, 1);
        chk("m2_ovf", OVF_O, 1);
        clr_pulse();
        chk("m2_clr_ovf", OVF_O, 0);
        chk("m2_clr_stb", STB_O, 1);

        // Ack in the same cycle as a new event: replace, stay pending, no overflow
        src_byte = 8'h07;
        wait_req(n);
        tick(3);
        ACK_I = 1'b1;
        tick(1);
        ACK_I = 1'b0;
        chk("ae_stb", STB_O, 1);
        chk("ae_evt", EVT_O, 8'h04);
        chk("ae_ovf", OVF_O, 0);
        ack_pulse();
        chk("ae_ack_stb", STB_O, 0);

        // Silent source: ERR_O sets on the 4th edge after the request is taken
        silent = 1'b1;
        wait_req(n);
        tick(4);
        chk("tmo_pre", ERR_O, 0);
        tick(1);
        chk("tmo_err", ERR_O, 1);
        chk("tmo_dat", DAT_O, 8'h07);
        silent = 1'b0;
        src_byte = 8'h0F;
        wait_req(n);
        chk("tmo_next_req", POLL_STB_O, 1);
        tick(4);
        chk("tmo_next_dat", DAT_O, 8'h0F);
        chk("tmo_next_evt", EVT_O, 8'h08);
        chk("tmo_err_sticky", ERR_O, 1);
        clr_pulse();
        chk("tmo_clr", ERR_O, 0);

        // Reset in WAIT with an event pending; late reply must be ignored
        src_byte = 8'h1F;
        wait_req(n);
        tick(1);
        RST_I = 1'b0;
        #1;
        chk("mr_stb", STB_O, 0);
        chk("mr_evt", EVT_O, 8'h00);
        chk("mr_dat", DAT_O, 8'h00);
        chk("mr_pstb", POLL_STB_O, 0);
        tick(1);
        RST_I = 1'b1;
        wait_req(n);
        chk("mr_restart", n, 8);
        chk("mr_late_dat", DAT_O, 8'h00);
        chk("mr_late_stb", STB_O, 0);
        tick(4);
        chk("mr_poll_evt", EVT_O, 8'h1F);
        chk("mr_poll_dat", DAT_O, 8'h1F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
